// File: rtl/dbx_tile_sched.sv
// dbx_tile_sched
//   Sequences a dBx multiplier array across one job of num_h heads x num_nt
//   N-tiles. Issues at most one (h, nt) pair per cycle, nt inner / h outer,
//   gated by credits for the downstream result FIFO. The {valid, h, nt, last}
//   tag of each issue travels down a MUL_LAT-stage shift line so it appears
//   alongside the matching dBx result.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   start_i                start a job (only honoured in IDLE)
//   num_h_i, num_nt_i      job dimensions, latched when start_i is accepted
//   busy_o                 job in progress (RUN or DRAIN)
//   done_o                 one-cycle pulse when the job completes
//   issue_valid_o          valid into the dBx lanes
//   issue_h_o, issue_nt_o  operand address of the current issue
//   dbx_valid_i            result valid coming back from the dBx lanes
//   out_valid_o            result valid to the FIFO (mirrors dbx_valid_i)
//   out_h_o, out_nt_o      tag aligned with the result
//   out_last_o             marks the final result of the job
//   credit_ret_i           FIFO popped one entry
//   err_o                  sticky protocol error (credit overflow, tag/valid skew)

module dbx_tile_sched #(
  parameter int H_W     = 4,
  parameter int NT_W    = 4,
  parameter int MUL_LAT = 6,
  parameter int CREDITS = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [H_W-1:0]  num_h_i,
  input  logic [NT_W-1:0] num_nt_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            issue_valid_o,
  output logic [H_W-1:0]  issue_h_o,
  output logic [NT_W-1:0] issue_nt_o,
  input  logic            dbx_valid_i,
  output logic            out_valid_o,
  output logic [H_W-1:0]  out_h_o,
  output logic [NT_W-1:0] out_nt_o,
  output logic            out_last_o,
  input  logic            credit_ret_i,
  output logic            err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  // Results can only be outstanding for MUL_LAT cycles; one spare bit of headroom.
  localparam int FW = $clog2(MUL_LAT + 2) + 1;
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic            valid;
    logic [H_W-1:0]  h;
    logic [NT_W-1:0] nt;
    logic            last;
  } tag_t;

  state_e          state_q, state_d;
  logic [H_W-1:0]  num_h_q, num_h_d;
  logic [NT_W-1:0] num_nt_q, num_nt_d;
  logic [H_W-1:0]  h_q, h_d;
  logic [NT_W-1:0] nt_q, nt_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [FW-1:0]   inflight_q, inflight_d;
  logic            issue_valid_q, issue_valid_d;
  logic [H_W-1:0]  issue_h_q, issue_h_d;
  logic [NT_W-1:0] issue_nt_q, issue_nt_d;
  logic            issue_last_q, issue_last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  tag_t            tag_q [MUL_LAT];
  tag_t            tag_d [MUL_LAT];

  logic            zero_job;
  logic            last_idx;
  logic            issue;
  logic            credit_ovf;
  tag_t            tag_head;

  assign tag_head = tag_q[MUL_LAT-1];

  // NOTE: every signal assigned in this block gets a default at the top, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    num_h_d      = num_h_q;
    num_nt_d     = num_nt_q;
    h_d          = h_q;
    nt_d         = nt_q;
    credit_d     = credit_q;
    inflight_d   = inflight_q;
    credit_ovf   = 1'b0;

    zero_job = (num_h_q == '0) || (num_nt_q == '0);
    last_idx = (h_q == num_h_q - 1'b1) && (nt_q == num_nt_q - 1'b1);
    // An issue consumes a credit; with none left the indices simply hold and a
    // bubble goes down the dBx pipe, which itself never stalls.
    issue    = (state_q == RUN) && !zero_job && (credit_q != '0);

    // Outstanding results: issue and return in the same cycle cancel out.
    if (issue && !dbx_valid_i) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && dbx_valid_i && (inflight_q != '0)) begin
      inflight_d = inflight_q - 1'b1;
    end

    // FIFO credits: a return while already full is a protocol error and is dropped.
    if (issue && !credit_ret_i) begin
      credit_d = credit_q - 1'b1;
    end else if (!issue && credit_ret_i) begin
      if (credit_q == CREDITS_MAX) begin
        credit_ovf = 1'b1;
      end else begin
        credit_d = credit_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          num_h_d  = num_h_i;
          num_nt_d = num_nt_i;
          h_d      = '0;
          nt_d     = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // An empty job passes through RUN for one cycle without issuing, which
        // keeps done_o at the same distance from start_i as the first issue.
        if (zero_job) begin
          state_d = DONE;
        end else if (issue) begin
          if (last_idx) begin
            state_d = DRAIN;
          end else if (nt_q == num_nt_q - 1'b1) begin
            nt_d = '0;
            h_d  = h_q + 1'b1;
          end else begin
            nt_d = nt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Leave as the final result comes back, not a cycle after it.
        if (inflight_d == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    issue_valid_d = issue;
    issue_h_d     = issue ? h_q  : '0;
    issue_nt_d    = issue ? nt_q : '0;
    issue_last_d  = issue && last_idx;

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    err_d  = err_q || credit_ovf || (dbx_valid_i != tag_head.valid);

    // The line is fed from the registered issue, so the head lines up with a
    // result that appears MUL_LAT cycles after issue_valid_o.
    tag_d[0].valid = issue_valid_q;
    tag_d[0].h     = issue_h_q;
    tag_d[0].nt    = issue_nt_q;
    tag_d[0].last  = issue_last_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      num_h_q       <= '0;
      num_nt_q      <= '0;
      h_q           <= '0;
      nt_q          <= '0;
      credit_q      <= CREDITS_MAX;
      inflight_q    <= '0;
      issue_valid_q <= 1'b0;
      issue_h_q     <= '0;
      issue_nt_q    <= '0;
      issue_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      // NOTE: the tag line is reset, unlike a data RAM, because a stale valid
      // bit left in it after an aborted job would be flagged as a protocol error.
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      num_h_q       <= num_h_d;
      num_nt_q      <= num_nt_d;
      h_q           <= h_d;
      nt_q          <= nt_d;
      credit_q      <= credit_d;
      inflight_q    <= inflight_d;
      issue_valid_q <= issue_valid_d;
      issue_h_q     <= issue_h_d;
      issue_nt_q    <= issue_nt_d;
      issue_last_q  <= issue_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign issue_valid_o = issue_valid_q;
  assign issue_h_o     = issue_h_q;
  assign issue_nt_o    = issue_nt_q;
  assign err_o         = err_q;

  // The result valid passes straight through; the tag is shown only with it.
  assign out_valid_o = dbx_valid_i;
  assign out_h_o     = dbx_valid_i ? tag_head.h    : '0;
  assign out_nt_o    = dbx_valid_i ? tag_head.nt   : '0;
  assign out_last_o  = dbx_valid_i ? tag_head.last : 1'b0;

endmodule

// File: tb/tb_dbx_tile_sched.sv
// tb_dbx_tile_sched
//   Self-checking bench for dbx_tile_sched. A fixed-latency model of the dBx
//   lanes returns dbx_valid_i MUL_LAT cycles after each issue. Every observed
//   issue is checked against the expected (h, nt) order and pushed to a
//   scoreboard queue; every result is popped and its tag and latency compared.

module tb_dbx_tile_sched;

  localparam int H_W  = 4;
  localparam int NT_W = 4;
  localparam int L    = 6;
  localparam int CR   = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start_i = 1'b0;
  logic [H_W-1:0]  num_h_i = '0;
  logic [NT_W-1:0] num_nt_i = '0;
  logic            busy_o, done_o, issue_valid_o, out_valid_o, out_last_o, err_o;
  logic [H_W-1:0]  issue_h_o, out_h_o;
  logic [NT_W-1:0] issue_nt_o, out_nt_o;
  logic            dbx_valid_i, credit_ret_i;

  logic            ret_mirror = 1'b0;
  logic            ret_manual = 1'b0;
  logic            spur = 1'b0;
  logic            sb_en = 1'b1;
  logic [L-1:0]    dpipe;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int   h;
    int   nt;
    logic last;
    int   cyc;
  } sb_t;
  sb_t sbq[$];
  int  icyc[$];

  int cur_nh, cur_nnt, exp_h, exp_nt;
  int issue_cnt, last_cnt, done_cnt;
  int start_cyc, done_cyc;

  dbx_tile_sched #(.H_W(H_W), .NT_W(NT_W), .MUL_LAT(L), .CREDITS(CR)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .num_h_i       (num_h_i),
    .num_nt_i      (num_nt_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .issue_valid_o (issue_valid_o),
    .issue_h_o     (issue_h_o),
    .issue_nt_o    (issue_nt_o),
    .dbx_valid_i   (dbx_valid_i),
    .out_valid_o   (out_valid_o),
    .out_h_o       (out_h_o),
    .out_nt_o      (out_nt_o),
    .out_last_o    (out_last_o),
    .credit_ret_i  (credit_ret_i),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // dBx lanes: fixed MUL_LAT-cycle valid delay.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) dpipe <= '0;
    else       dpipe <= {dpipe[L-2:0], issue_valid_o};
  end
  assign dbx_valid_i  = dpipe[L-1] | spur;
  assign credit_ret_i = ret_mirror ? issue_valid_o : ret_manual;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (sb_en && issue_valid_o) begin
        check("issue_h", 64'(issue_h_o), 64'(exp_h));
        check("issue_nt", 64'(issue_nt_o), 64'(exp_nt));
        sbq.push_back('{h: exp_h, nt: exp_nt,
                        last: (exp_h == cur_nh - 1) && (exp_nt == cur_nnt - 1), cyc: cyc});
        icyc.push_back(cyc);
        issue_cnt++;
        if (exp_nt == cur_nnt - 1) begin
          exp_nt = 0;
          exp_h++;
        end else begin
          exp_nt++;
        end
      end
      if (sb_en && out_valid_o) begin
        if (sbq.size() == 0) begin
          check("out_unexpected", 64'(out_valid_o), 64'd0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check("out_h", 64'(out_h_o), 64'(e.h));
          check("out_nt", 64'(out_nt_o), 64'(e.nt));
          check("out_last", 64'(out_last_o), 64'(e.last));
          check("out_latency", 64'(cyc), 64'(e.cyc + L));
          if (out_last_o) last_cnt++;
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Called just after a rising edge; start_i is held for one cycle.
  task automatic start_job(input int nh, input int nnt);
    num_h_i   = H_W'(nh);
    num_nt_i  = NT_W'(nnt);
    cur_nh    = nh;
    cur_nnt   = nnt;
    exp_h     = 0;
    exp_nt    = 0;
    issue_cnt = 0;
    last_cnt  = 0;
    done_cnt  = 0;
    icyc.delete();
    start_i   = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(posedge clk); #2;
      n++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
  endtask

  // Asserts reset mid-cycle, checks the outputs clear at once, then releases.
  task automatic apply_reset();
    ret_mirror = 1'b0;
    ret_manual = 1'b0;
    spur       = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("reset_outputs",
          64'({busy_o, done_o, issue_valid_o, issue_h_o, issue_nt_o,
               out_valid_o, out_h_o, out_nt_o, out_last_o, err_o}), 64'd0);
    sbq.delete();
    icyc.delete();
    issue_cnt = 0;
    last_cnt  = 0;
    done_cnt  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int nh;
    int nnt;
    int exp_issues;
    int exp_lasts;
  } job_t;

  localparam int NV = 8;
  job_t jobs [NV];

  task automatic run_t1(input string tag);
    ret_mirror = 1'b1;
    start_job(2, 3);
    wait_done(100);
    repeat (L + 4) @(posedge clk);
    #1;
    check({tag, "_issues"}, 64'(issue_cnt), 64'd6);
    check({tag, "_lasts"}, 64'(last_cnt), 64'd1);
    check({tag, "_done"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
    ret_mirror = 1'b0;
  endtask

  initial begin
    jobs[0] = '{nh: 2,  nnt: 3, exp_issues: 6,  exp_lasts: 1};
    jobs[1] = '{nh: 1,  nnt: 1, exp_issues: 1,  exp_lasts: 1};
    jobs[2] = '{nh: 3,  nnt: 2, exp_issues: 6,  exp_lasts: 1};
    jobs[3] = '{nh: 1,  nnt: 5, exp_issues: 5,  exp_lasts: 1};
    jobs[4] = '{nh: 4,  nnt: 4, exp_issues: 16, exp_lasts: 1};
    jobs[5] = '{nh: 15, nnt: 1, exp_issues: 15, exp_lasts: 1};
    jobs[6] = '{nh: 0,  nnt: 3, exp_issues: 0,  exp_lasts: 0};
    jobs[7] = '{nh: 2,  nnt: 0, exp_issues: 0,  exp_lasts: 0};

    // Reset state
    #1;
    check("reset_init_outputs",
          64'({busy_o, done_o, issue_valid_o, issue_h_o, issue_nt_o,
               out_valid_o, out_h_o, out_nt_o, out_last_o, err_o}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Table of jobs with credits returned as fast as results are issued
    for (int i = 0; i < NV; i++) begin
      ret_mirror = 1'b1;
      start_job(jobs[i].nh, jobs[i].nnt);
      wait_done(200);
      repeat (L + 4) @(posedge clk);
      #1;
      check($sformatf("job%0d_issues", i), 64'(issue_cnt), 64'(jobs[i].exp_issues));
      check($sformatf("job%0d_lasts", i), 64'(last_cnt), 64'(jobs[i].exp_lasts));
      check($sformatf("job%0d_done", i), 64'(done_cnt), 64'd1);
      check($sformatf("job%0d_busy_after", i), 64'(busy_o), 64'd0);
      check($sformatf("job%0d_sb_empty", i), 64'(sbq.size()), 64'd0);
      check($sformatf("job%0d_err", i), 64'(err_o), 64'd0);
      if (jobs[i].exp_issues > 0) begin
        check($sformatf("job%0d_start_to_issue", i), 64'(icyc[0] - start_cyc), 64'd2);
        check($sformatf("job%0d_last_to_done", i),
              64'(done_cyc - icyc[icyc.size()-1]), 64'(L + 1));
      end else begin
        check($sformatf("job%0d_start_to_done", i), 64'(done_cyc - start_cyc), 64'd2);
      end
      ret_mirror = 1'b0;
    end

    // A second start while busy is ignored
    ret_mirror = 1'b1;
    start_job(2, 3);
    @(posedge clk); #1;
    num_h_i  = 4'd1;
    num_nt_i = 4'd1;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    wait_done(100);
    repeat (20) @(posedge clk);
    #1;
    check("busy_restart_issues", 64'(issue_cnt), 64'd6);
    check("busy_restart_done", 64'(done_cnt), 64'd1);
    ret_mirror = 1'b0;

    // Credit starvation: 8 issues, then one issue per returned credit
    start_job(4, 4);
    repeat (20) @(posedge clk);
    #1;
    check("stall_issues", 64'(issue_cnt), 64'd8);
    check("stall_busy", 64'(busy_o), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      ret_manual = 1'b1;
      @(posedge clk); #1;
      ret_manual = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("ret_release_%0d", k), 64'(issue_cnt), 64'(8 + k));
    end
    // Holding the return high: credits sit at 1 while issuing every cycle
    ret_manual = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ret_manual = 1'b0;
    wait_done(100);
    repeat (L + 4) @(posedge clk);
    #1;
    check("credit1_issues", 64'(issue_cnt), 64'd16);
    check("credit1_back_to_back", 64'(icyc[15] - icyc[12]), 64'd3);
    check("credit1_done", 64'(done_cnt), 64'd1);
    ret_manual = 1'b1;
    repeat (CR) @(posedge clk);
    #1;
    ret_manual = 1'b0;
    @(posedge clk); #1;
    check("credit_refill_err", 64'(err_o), 64'd0);

    // Empty job: no issue, done two cycles after start, start in DONE ignored
    start_job(0, 3);
    check("zero_done_early", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    check("zero_done_pulse", 64'(done_o), 64'd1);
    num_h_i  = 4'd1;
    num_nt_i = 4'd1;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    check("zero_done_single", 64'(done_o), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("zero_no_issue", 64'(issue_cnt), 64'd0);
    check("zero_idle", 64'(busy_o), 64'd0);

    // Spurious result with an empty tag line
    sb_en = 1'b0;
    spur  = 1'b1;
    #1;
    check("spur_out_valid", 64'(out_valid_o), 64'd1);
    check("spur_out_tag", 64'({out_h_o, out_nt_o, out_last_o}), 64'd0);
    @(posedge clk); #1;
    spur = 1'b0;
    check("spur_err", 64'(err_o), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("spur_err_sticky", 64'(err_o), 64'd1);
    sb_en = 1'b1;

    // Extra credit return while full: error, count stays at CREDITS
    apply_reset();
    check("ovf_err_clear", 64'(err_o), 64'd0);
    ret_manual = 1'b1;
    @(posedge clk); #1;
    ret_manual = 1'b0;
    check("ovf_err", 64'(err_o), 64'd1);
    start_job(4, 4);
    repeat (20) @(posedge clk);
    #1;
    check("ovf_credit_saturated", 64'(issue_cnt), 64'd8);

    // Reset in the middle of an issuing job
    apply_reset();
    start_job(4, 4);
    repeat (3) @(posedge clk);
    #1;
    check("midrun_issuing", 64'(issue_valid_o), 64'd1);
    apply_reset();
    repeat (20) @(posedge clk);
    #1;
    check("midrun_no_done", 64'(done_cnt), 64'd0);
    check("midrun_no_issue", 64'(issue_cnt), 64'd0);
    start_job(4, 4);
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_credits", 64'(issue_cnt), 64'd8);
    apply_reset();
    run_t1("post_reset_t1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
